// File: rtl/telem_framer.sv
// telem_framer: builds telemetry frames from a sensor register map.
// A frame is SYNC0, SYNC1, SEQ, LEN, then NUM_BYTES payload bytes read from
// addresses FIRST_ADDR.. (mod 256), optionally followed by a checksum byte.
// Output uses a valid/ready handshake; each payload byte is fetched in a
// dedicated FETCH cycle before it is offered to the consumer.
// Optional feature: define TELEM_FRAMER_CHECKSUM_EN to append the CSUM byte
// (two's complement of the mod-256 sum of SEQ, LEN and the payload).
module telem_framer #(
  parameter logic [7:0] FIRST_ADDR = 8'd1,
  parameter int         NUM_BYTES  = 25,
  parameter logic [7:0] SYNC0      = 8'hA5,
  parameter logic [7:0] SYNC1      = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] addr,
  input  logic [7:0] data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam logic [7:0] LEN_BYTE = 8'(NUM_BYTES);
  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC0,
    ST_SYNC1,
    ST_SEQ,
    ST_LEN,
    ST_FETCH,
    ST_PAYLOAD,
`ifdef TELEM_FRAMER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] seq;
  logic [7:0] idx;
  logic [7:0] pay_byte;
  logic       xfer;
`ifdef TELEM_FRAMER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign xfer = tx_valid & tx_ready;

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: header and payload states advance only on a transfer.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (start) next_state = ST_SYNC0;
      ST_SYNC0:   if (xfer)  next_state = ST_SYNC1;
      ST_SYNC1:   if (xfer)  next_state = ST_SEQ;
      ST_SEQ:     if (xfer)  next_state = ST_LEN;
      ST_LEN:     if (xfer)  next_state = ST_FETCH;
      ST_FETCH:   next_state = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
`ifdef TELEM_FRAMER_CHECKSUM_EN
            next_state = ST_CSUM;
`else
            next_state = ST_DONE;
`endif
          end else begin
            next_state = ST_FETCH;
          end
        end
      end
`ifdef TELEM_FRAMER_CHECKSUM_EN
      ST_CSUM:    if (xfer)  next_state = ST_DONE;
`endif
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output decode: byte mux, handshake valid, register address and status.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    addr     = 8'h00;
    unique case (state)
      ST_SYNC0: begin
        tx_valid = 1'b1;
        tx_data  = SYNC0;
      end
      ST_SYNC1: begin
        tx_valid = 1'b1;
        tx_data  = SYNC1;
      end
      ST_SEQ: begin
        tx_valid = 1'b1;
        tx_data  = seq;
      end
      ST_LEN: begin
        tx_valid = 1'b1;
        tx_data  = LEN_BYTE;
      end
      ST_FETCH: begin
        addr = FIRST_ADDR + idx;
      end
      ST_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = pay_byte;
        addr     = FIRST_ADDR + idx;
      end
`ifdef TELEM_FRAMER_CHECKSUM_EN
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = 8'h00 - sum;
      end
`endif
      default: begin
        tx_valid = 1'b0;
      end
    endcase
    busy       = (state != ST_IDLE);
    frame_done = (state == ST_DONE);
    overrun    = start & (state != ST_IDLE);
  end

  // Datapath: payload index, captured register byte, sequence number and sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq      <= 8'h00;
      idx      <= 8'h00;
      pay_byte <= 8'h00;
`ifdef TELEM_FRAMER_CHECKSUM_EN
      sum      <= 8'h00;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          idx <= 8'h00;
`ifdef TELEM_FRAMER_CHECKSUM_EN
          if (start) sum <= seq + LEN_BYTE;
`endif
        end
        ST_FETCH: begin
          pay_byte <= data;
`ifdef TELEM_FRAMER_CHECKSUM_EN
          sum      <= sum + data;
`endif
        end
        ST_PAYLOAD: begin
          if (xfer) idx <= idx + 8'd1;
        end
        ST_DONE: begin
          seq <= seq + 8'd1;
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_telem_framer.sv
// tb_telem_framer: scoreboard bench for telem_framer.
// Stimulus pushes each expected frame into a queue when it issues start;
// a negedge monitor pops and compares on every transfer, and also checks
// stall stability, frame length and frame_done latency.
module tb_telem_framer;

  localparam logic [7:0] FIRST_ADDR = 8'd1;
  localparam int         NUM_BYTES  = 25;
  localparam logic [7:0] SYNC0      = 8'hA5;
  localparam logic [7:0] SYNC1      = 8'h5A;
`ifdef TELEM_FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = NUM_BYTES + 5;
`else
  localparam int FRAME_LEN = NUM_BYTES + 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] addr;
  logic [7:0] data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  logic [7:0] data_mask;
  logic [7:0] tb_seq;
  bit         rand_ready;
  logic [7:0] exp_q[$];

  int chks = 0;
  int errs = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int xfer_cnt = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  telem_framer #(
    .FIRST_ADDR(FIRST_ADDR),
    .NUM_BYTES (NUM_BYTES),
    .SYNC0     (SYNC0),
    .SYNC1     (SYNC1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr      (addr),
    .data      (data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  // Register-map model: byte read back is the address, optionally scrambled.
  assign data = addr ^ data_mask;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    chks++;
    errs++;
    $display("[TB] FAIL %s: timeout waiting for DUT", name);
  endtask

  // Queue the full expected byte stream of one frame.
  task automatic pushFrame(input logic [7:0] s, input logic [7:0] mask);
    logic [7:0] acc;
    logic [7:0] b;
    exp_q.push_back(SYNC0);
    exp_q.push_back(SYNC1);
    exp_q.push_back(s);
    exp_q.push_back(8'(NUM_BYTES));
    acc = s + 8'(NUM_BYTES);
    for (int i = 0; i < NUM_BYTES; i++) begin
      b = (FIRST_ADDR + 8'(i)) ^ mask;
      exp_q.push_back(b);
      acc = acc + b;
    end
`ifdef TELEM_FRAMER_CHECKSUM_EN
    exp_q.push_back(8'h00 - acc);
`endif
  endtask

  // Wait for idle, queue the expected frame and pulse start for one cycle.
  task automatic applyStimulus(input logic [7:0] mask);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) timeoutFail("idle_wait");
    data_mask = mask;
    pushFrame(tb_seq, mask);
    tb_seq = tb_seq + 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Return inside the DONE cycle, #1 after its rising edge.
  task automatic waitDone();
    int n = 0;
    while (!frame_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!frame_done) timeoutFail("frame_done_wait");
  endtask

  // Consumer ready: always 1, or pseudo-random when stalls are enabled.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      else            tx_ready = 1'b1;
    end
  end

  // Monitor: scoreboard pops, stall stability, length and done latency.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      xfer_cnt   = 0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(tx_valid), 32'd1);
        checkOutput("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chks++;
          errs++;
          $display("[TB] FAIL unexpected_byte: actual %0h required none", tx_data);
        end else begin
          checkOutput("frame_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        checkOutput("done_latency", 32'(cyc - last_xfer_cyc), 32'd1);
        checkOutput("frame_len", 32'(xfer_cnt), 32'(FRAME_LEN));
        xfer_cnt = 0;
      end
      if (overrun) ovr_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    int d0;
    int o0;
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    data_mask  = 8'h00;
    rand_ready = 1'b0;
    tb_seq     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);

    $display("[TB] reset wins over start");
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rst_prio_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_prio_busy2", 32'(busy), 32'd0);

    $display("[TB] scenario 1: single frame, ready high");
    d0 = done_cnt;
    applyStimulus(8'h00);
    waitDone();
    @(posedge clk); #1;
    checkOutput("s1_busy_after", 32'(busy), 32'd0);
    checkOutput("s1_done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("s1_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] scenario 2: random ready");
    rand_ready = 1'b1;
    applyStimulus(8'h00);
    waitDone();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("s2_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] scenario 3: start while busy and in DONE");
    d0 = done_cnt;
    o0 = ovr_cnt;
    applyStimulus(8'h3C);
    n = 0;
    while (!(tx_valid && busy && addr == FIRST_ADDR + 8'd5) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) timeoutFail("s3_payload5_wait");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("s3_overrun_mid", 32'(ovr_cnt - o0), 32'd1);
    waitDone();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("s3_overrun_done", 32'(ovr_cnt - o0), 32'd2);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("s3_busy_after", 32'(busy), 32'd0);
    checkOutput("s3_done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("s3_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] scenario 5: reset during FETCH of byte 10");
    d0 = done_cnt;
    applyStimulus(8'h00);
    n = 0;
    while (!(busy && !tx_valid && !frame_done && addr == FIRST_ADDR + 8'd10) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) timeoutFail("s5_fetch10_wait");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("s5_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("s5_addr", 32'(addr), 32'd0);
    checkOutput("s5_busy", 32'(busy), 32'd0);
    checkOutput("s5_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    repeat (40) begin
      @(posedge clk); #1;
    end
    checkOutput("s5_no_done", 32'(done_cnt - d0), 32'd0);
    tb_seq = 8'h00;
    applyStimulus(8'h00);
    waitDone();
    @(posedge clk); #1;
    checkOutput("s5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] scenario 4: 257 back-to-back frames");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tb_seq = 8'h00;
    d0 = done_cnt;
    for (int f = 0; f < 257; f++) begin
      applyStimulus(8'h00);
      waitDone();
    end
    @(posedge clk); #1;
    checkOutput("s4_done_count", 32'(done_cnt - d0), 32'd257);
    checkOutput("s4_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("s4_busy_after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", chks, errs);
    $finish;
  end

endmodule

// File: doc/telem_framer.md
TELEM_FRAMER -- requirements
Module: telem_framer

Interface
REQ-001 SHALL have parameter FIRST_ADDR, default 8'd1, meaning the first sensor register address read.
REQ-002 SHALL have parameter NUM_BYTES, default 25, meaning the payload byte count; legal range 1..255.
REQ-003 SHALL have parameter SYNC0, default 8'hA5, meaning the first frame sync byte.
REQ-004 SHALL have parameter SYNC1, default 8'h5A, meaning the second frame sync byte.
REQ-005 SHALL have port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port: start  input  1  frame request; sampled each cycle.
REQ-008 SHALL have port: addr  output  8  register-map address driven to the sensor register block.
REQ-009 SHALL have port: data  input  8  register-map read byte; valid one cycle after addr changes.
REQ-010 SHALL have port: tx_data  output  8  outgoing frame byte.
REQ-011 SHALL have port: tx_valid  output  1  tx_data holds a byte for the consumer.
REQ-012 SHALL have port: tx_ready  input  1  consumer accepts the byte.
REQ-013 SHALL have port: busy  output  1  high from frame acceptance until the frame_done cycle.
REQ-014 SHALL have port: frame_done  output  1  one-cycle pulse after the last byte transfers.
REQ-015 SHALL have port: overrun  output  1  one-cycle pulse when start arrives while busy.

Function
REQ-016 Transfers SHALL occur only on cycles with tx_valid=1 and tx_ready=1; tx_data SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-017 Frame order SHALL be: SYNC0, SYNC1, SEQ, LEN (=NUM_BYTES), NUM_BYTES payload bytes, then CSUM when enabled.
REQ-018 States SHALL be IDLE, SYNC0, SYNC1, SEQ, LEN, FETCH, PAYLOAD, CSUM, DONE.
REQ-019 IDLE SHALL move to SYNC0 on start=1; each header state and PAYLOAD SHALL advance only on a transfer.
REQ-020 LEN SHALL move to FETCH on transfer; FETCH SHALL last exactly one cycle with addr=FIRST_ADDR+i, then load data into tx_data and enter PAYLOAD.
REQ-021 PAYLOAD SHALL return to FETCH for byte i+1 on transfer of byte i; after byte NUM_BYTES-1 it SHALL enter CSUM when enabled, otherwise DONE.
REQ-022 DONE SHALL assert frame_done for one cycle, increment SEQ, and return to IDLE; SEQ SHALL wrap 8'hFF to 8'h00.
REQ-023 tx_valid SHALL be 0 in IDLE, FETCH and DONE, and 1 in all other states.
REQ-024 addr SHALL be 8'h00 in every state except FETCH and PAYLOAD, and SHALL hold FIRST_ADDR+i through PAYLOAD.
REQ-025 The payload address SHALL be computed modulo 256.
REQ-026 start while busy SHALL be ignored, pulse overrun, and leave the frame unaffected.
REQ-027 start in the DONE cycle SHALL be treated as busy, i.e. ignored, with overrun pulsed.
REQ-028 A frame SHALL be at least NUM_BYTES+4 transfers plus NUM_BYTES FETCH cycles plus 1 DONE cycle long.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL enter IDLE and set SEQ=0, addr=0, tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0 and the running sum to 0.
REQ-030 Reset mid-frame SHALL abandon the frame without emitting further bytes or asserting frame_done.
REQ-031 rst SHALL take priority over start on the same edge.

Configuration
REQ-032 Macro TELEM_FRAMER_CHECKSUM_EN, when defined, SHALL include the CSUM state.
REQ-033 CSUM SHALL be the two's complement of the mod-256 sum of SEQ, LEN and all payload bytes, so the mod-256 sum of SEQ through CSUM equals 0.
REQ-034 When TELEM_FRAMER_CHECKSUM_EN is undefined, the CSUM state and sum logic SHALL be absent, and PAYLOAD SHALL go directly to DONE.

Verification
REQ-035 Scenario 1: defaults, checksum enabled, tx_ready=1, data=addr, one start -> stream A5 5A 00 19 01..19 (hex) then CSUM; SEQ+LEN+payload bytes+CSUM sum to 0 mod 256; frame_done pulses once; busy is low afterwards.
REQ-036 Scenario 2: tx_ready toggled pseudo-randomly -> byte sequence identical to scenario 1, and tx_data never changes while tx_valid=1 and tx_ready=0.
REQ-037 Scenario 3: start pulsed during payload byte 5 -> overrun pulses once, the current frame completes unchanged, and no second frame starts.
REQ-038 Scenario 4: 257 back-to-back frames -> the SEQ byte runs 00..FF, then 00.
REQ-039 Scenario 5: rst asserted during FETCH of byte 10 -> next cycle IDLE with tx_valid=0, addr=0, SEQ=0, and no frame_done; a new start then produces a full frame with SEQ=00.
REQ-040 Scenario 6: build without TELEM_FRAMER_CHECKSUM_EN -> frame is 29 bytes ending at payload byte 0x19, and frame_done follows the last transfer by one cycle.
